// File: rtl/fft_buffer_pkg.sv
// Shared defaults for the SFFT inter-stage frame buffers.
// Word layout is a packed complex sample: {re, im}, each one SFFT output wide.
package fft_buffer_pkg;

  localparam int NFFT           = 512;
  localparam int SFFT_OUT_WIDTH = 24;
  localparam int BUF_ADDR_WIDTH = $clog2(NFFT);
  localparam int BUF_DATA_WIDTH = 2 * SFFT_OUT_WIDTH;

  typedef struct packed {
    logic signed [SFFT_OUT_WIDTH-1:0] re;
    logic signed [SFFT_OUT_WIDTH-1:0] im;
  } cplx_word_t;

endpackage

// File: rtl/dp_bank_ram.sv
// One frame bank: two write ports (port B wins on same-address collision) and
// two registered read ports whose data holds its last value when not enabled.
module dp_bank_ram
  import fft_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = BUF_DATA_WIDTH,
  parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;

  // Storage is deliberately not reset; port B is written last so it wins.
  always_ff @(posedge clk) begin
    if (we_a) mem_q[waddr_a] <= wdata_a;
    if (we_b) mem_q[waddr_b] <= wdata_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a) rdata_a_q <= mem_q[raddr_a];
      if (re_b) rdata_b_q <= mem_q[raddr_b];
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/fft_pingpong_buffer.sv
// Two-bank ping-pong frame buffer between SFFT stages: producer fills one bank
// while consumer reads the committed one; handover via commit/release pulses.
module fft_pingpong_buffer
  import fft_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = BUF_DATA_WIDTH,
  parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [DATA_WIDTH-1:0] wr_data_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_data_b,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic                  rd_release,
  output logic                  frame_valid,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           frames_done
);

  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [1:0]  count_q, count_d;
  logic        rd_valid_a_q, rd_valid_a_d;
  logic        rd_valid_b_q, rd_valid_b_d;
  logic        rd_sel_a_q, rd_sel_a_d;
  logic        rd_sel_b_q, rd_sel_b_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic [15:0] frames_done_q, frames_done_d;

  logic wr_ok_a, wr_ok_b, rd_ok_a, rd_ok_b;
  logic commit_acc, release_acc;

  logic [DATA_WIDTH-1:0] bank_rdata_a [2];
  logic [DATA_WIDTH-1:0] bank_rdata_b [2];

  assign wr_ready    = (count_q != 2'd2);
  assign frame_valid = (count_q != 2'd0);

  assign wr_ok_a     = wr_en_a & wr_ready;
  assign wr_ok_b     = wr_en_b & wr_ready;
  assign rd_ok_a     = rd_en_a & frame_valid;
  assign rd_ok_b     = rd_en_b & frame_valid;
  assign commit_acc  = wr_commit & wr_ready;
  assign release_acc = rd_release & frame_valid;

  // Bank enables use the pre-update pointers, so commit/release-cycle
  // accesses still target the old banks.
  for (genvar k = 0; k < 2; k++) begin : g_bank
    dp_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .we_a   (wr_ok_a & (wr_bank_q == 1'(k))),
      .waddr_a(wr_addr_a),
      .wdata_a(wr_data_a),
      .we_b   (wr_ok_b & (wr_bank_q == 1'(k))),
      .waddr_b(wr_addr_b),
      .wdata_b(wr_data_b),
      .re_a   (rd_ok_a & (rd_bank_q == 1'(k))),
      .raddr_a(rd_addr_a),
      .re_b   (rd_ok_b & (rd_bank_q == 1'(k))),
      .raddr_b(rd_addr_b),
      .rdata_a(bank_rdata_a[k]),
      .rdata_b(bank_rdata_b[k])
    );
  end

  always_comb begin
    wr_bank_d     = wr_bank_q ^ commit_acc;
    rd_bank_d     = rd_bank_q ^ release_acc;
    count_d       = count_q;
    case ({commit_acc, release_acc})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    rd_valid_a_d  = rd_ok_a;
    rd_valid_b_d  = rd_ok_b;
    // Output mux follows the bank of the most recent read so held data stays put.
    rd_sel_a_d    = rd_ok_a ? rd_bank_q : rd_sel_a_q;
    rd_sel_b_d    = rd_ok_b ? rd_bank_q : rd_sel_b_q;
    overflow_d    = overflow_q | (wr_commit & ~wr_ready);
    underflow_d   = underflow_q | (rd_release & ~frame_valid);
    frames_done_d = frames_done_q + {15'd0, release_acc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      count_q       <= 2'd0;
      rd_valid_a_q  <= 1'b0;
      rd_valid_b_q  <= 1'b0;
      rd_sel_a_q    <= 1'b0;
      rd_sel_b_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      frames_done_q <= 16'd0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      count_q       <= count_d;
      rd_valid_a_q  <= rd_valid_a_d;
      rd_valid_b_q  <= rd_valid_b_d;
      rd_sel_a_q    <= rd_sel_a_d;
      rd_sel_b_q    <= rd_sel_b_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign rd_data_a   = bank_rdata_a[rd_sel_a_q];
  assign rd_data_b   = bank_rdata_b[rd_sel_b_q];
  assign rd_valid_a  = rd_valid_a_q;
  assign rd_valid_b  = rd_valid_b_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign frames_done = frames_done_q;

endmodule
